// File: rtl/alu_cdb_queue.sv
// alu_cdb_queue: small FIFO between one integer ALU and the CDB arbiter.
// It captures ALU results as {tag, value} entries and offers the oldest entry
// to the arbiter with a req/grant handshake. alu_ready back-pressures issue.
// squash flushes all buffered results. overflow is sticky until reset.
// Optional feature: define ALU_CDB_BYPASS_EN for a zero-latency path from the
// ALU to the CDB while the queue is empty.
module alu_cdb_queue #(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = 6,
  parameter int CNT_BITS      = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     alu_valid,
  input  logic [PHYS_REG_BITS-1:0] alu_dest_tag,
  input  logic [31:0]              alu_result,
  output logic                     alu_ready,
  input  logic                     squash,
  output logic                     cdb_req,
  input  logic                     cdb_grant,
  output logic [PHYS_REG_BITS-1:0] cdb_tag,
  output logic [31:0]              cdb_value,
  output logic [CNT_BITS-1:0]      count,
  output logic                     overflow
);

  localparam int PTR_BITS = $clog2(DEPTH);

  // Entry storage; deliberately not reset, validity is tracked by count_q.
  logic [PHYS_REG_BITS-1:0] tag_mem   [DEPTH];
  logic [31:0]              value_mem [DEPTH];

  logic [PTR_BITS-1:0] head_q, head_d;
  logic [PTR_BITS-1:0] tail_q, tail_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic                overflow_q, overflow_d;

  logic not_empty;
  logic bypass_hit;
  logic push;
  logic pop;

  assign not_empty = (count_q != '0);
  assign alu_ready = (count_q != CNT_BITS'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef ALU_CDB_BYPASS_EN
  // An empty queue forwards the live ALU result straight onto the CDB.
  assign bypass_hit = !not_empty && alu_valid && !squash;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed result that is granted in the same cycle never needs a slot.
  assign push = alu_valid && alu_ready && !squash && !(bypass_hit && cdb_grant);
  assign pop  = not_empty && cdb_grant && !squash;

  // CDB side: head entry when occupied, bypass data when forwarding, else 0.
  always_comb begin
    cdb_req   = not_empty;
    cdb_tag   = '0;
    cdb_value = '0;
    if (not_empty) begin
      cdb_tag   = tag_mem[head_q];
      cdb_value = value_mem[head_q];
    end else if (bypass_hit) begin
      cdb_req   = 1'b1;
      cdb_tag   = alu_dest_tag;
      cdb_value = alu_result;
    end
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (alu_valid && !alu_ready) begin
      overflow_d = 1'b1;
    end
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_BITS'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Write the accepted result into the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      tag_mem[tail_q]   <= alu_dest_tag;
      value_mem[tail_q] <= alu_result;
    end
  end

endmodule

// File: tb/tb_alu_cdb_queue.sv
// Testbench for alu_cdb_queue: directed stimulus with a scoreboard queue of
// expected broadcasts, popped by a negedge monitor on every CDB handshake.
module tb_alu_cdb_queue;

  localparam int DEPTH = 4;
  localparam int TB    = 6;
  localparam int CB    = $clog2(DEPTH + 1);

`ifdef ALU_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n;
  logic          alu_valid;
  logic [TB-1:0] alu_dest_tag;
  logic [31:0]   alu_result;
  logic          alu_ready;
  logic          squash;
  logic          cdb_req;
  logic          cdb_grant;
  logic [TB-1:0] cdb_tag;
  logic [31:0]   cdb_value;
  logic [CB-1:0] count;
  logic          overflow;

  int total  = 0;
  int passed = 0;

  logic [TB-1:0] exp_tag_q [$];
  logic [31:0]   exp_val_q [$];

  alu_cdb_queue #(.DEPTH(DEPTH), .PHYS_REG_BITS(TB)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_dest_tag(alu_dest_tag), .alu_result(alu_result),
    .alu_ready(alu_ready), .squash(squash),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("check %-22s act=%0h exp=%0h ok", name, act, exp);
    end else begin
      $display("FAIL %-22s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one ALU result; record it as an expected broadcast when accepted.
  task automatic drive(input logic [TB-1:0] tag, input logic [31:0] val, input bit expect_bcast);
    alu_valid    = 1'b1;
    alu_dest_tag = tag;
    alu_result   = val;
    if (expect_bcast) begin
      exp_tag_q.push_back(tag);
      exp_val_q.push_back(val);
    end
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && cdb_req && cdb_grant && !squash) begin
      if (exp_tag_q.size() == 0) begin
        total++;
        $display("FAIL %-22s act=%0h exp=none", "unexpected_bcast", cdb_tag);
      end else begin
        logic [TB-1:0] et;
        logic [31:0]   ev;
        et = exp_tag_q.pop_front();
        ev = exp_val_q.pop_front();
        check("bcast_tag", 32'(cdb_tag), 32'(et));
        check("bcast_value", cdb_value, ev);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL %-22s act=timeout exp=finish", "watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; alu_valid = 1'b0; alu_dest_tag = '0; alu_result = '0;
    squash = 1'b0; cdb_grant = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    check("rst_count", 32'(count), 0);
    check("rst_cdb_req", 32'(cdb_req), 0);
    check("rst_cdb_tag", 32'(cdb_tag), 0);
    check("rst_cdb_value", cdb_value, 0);
    check("rst_alu_ready", 32'(alu_ready), 1);
    check("rst_overflow", 32'(overflow), 0);

    // Single push with grant held high.
    tick();
    cdb_grant = 1'b1;
    drive(6'd5, 32'h1234, 1'b1);
    @(negedge clock);
    check("single_req_c1", 32'(cdb_req), 32'(BYP));
    tick();
    alu_valid = 1'b0;
    @(negedge clock);
    check("single_req_c2", 32'(cdb_req), 32'(!BYP));
    tick();
    check("single_count_end", 32'(count), 0);

    // Fill without grant.
    cdb_grant = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      drive(TB'(t), 32'hA0 + 32'(t), 1'b1);
      tick();
    end
    alu_valid = 1'b0;
    check("fill_count", 32'(count), 4);
    check("fill_ready", 32'(alu_ready), 0);

    // Result arriving while full is dropped and flagged.
    drive(6'd9, 32'h9999, 1'b0);
    tick();
    alu_valid = 1'b0;
    check("ovf_count", 32'(count), 4);
    check("ovf_flag", 32'(overflow), 1);

    // Drain in order.
    cdb_grant = 1'b1;
    tick();
    check("drain_ready", 32'(alu_ready), 1);
    repeat (3) tick();
    check("drain_count", 32'(count), 0);
    check("drain_ovf_sticky", 32'(overflow), 1);

    // Steady stream, wrapping pointers several times.
    for (int i = 0; i < 20; i++) begin
      drive(TB'(10 + i), 32'h1000 + 32'(i), 1'b1);
      tick();
      check("stream_count", 32'(count), BYP ? 0 : 1);
    end
    alu_valid = 1'b0;
    tick();
    tick();
    check("stream_count_end", 32'(count), 0);

    // Squash with 3 entries, concurrent push and grant ignored.
    cdb_grant = 1'b0;
    for (int t = 0; t < 3; t++) begin
      drive(TB'(40 + t), 32'h4000 + 32'(t), 1'b1);
      tick();
    end
    alu_valid = 1'b0;
    check("sq_pre_count", 32'(count), 3);
    squash = 1'b1;
    cdb_grant = 1'b1;
    drive(6'd43, 32'h4343, 1'b0);
    exp_tag_q.delete();
    exp_val_q.delete();
    tick();
    squash = 1'b0;
    alu_valid = 1'b0;
    check("sq_count", 32'(count), 0);
    check("sq_cdb_req", 32'(cdb_req), 0);
    check("sq_overflow", 32'(overflow), 1);
    tick();
    tick();

    // Asynchronous reset between edges with 2 entries queued.
    cdb_grant = 1'b0;
    drive(6'd50, 32'h5050, 1'b1);
    tick();
    drive(6'd51, 32'h5151, 1'b1);
    tick();
    alu_valid = 1'b0;
    check("ar_pre_count", 32'(count), 2);
    #2 reset_n = 1'b0;
    #1;
    check("ar_cdb_req", 32'(cdb_req), 0);
    check("ar_count", 32'(count), 0);
    check("ar_cdb_value", cdb_value, 0);
    check("ar_alu_ready", 32'(alu_ready), 1);
    check("ar_overflow", 32'(overflow), 0);
    exp_tag_q.delete();
    exp_val_q.delete();
    tick();
    reset_n = 1'b1;

    // Queue still works after reset.
    cdb_grant = 1'b1;
    drive(6'd7, 32'h77, 1'b1);
    tick();
    alu_valid = 1'b0;
    tick();
    tick();
    check("post_count", 32'(count), 0);
    check("sb_drained", 32'(exp_tag_q.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_cdb_queue.md
# alu_cdb_queue

Result-side buffer that sits between one integer ALU and the common data bus (CDB) arbiter. Each cycle it captures the ALU's combinational result and destination physical-register tag into a small FIFO, then presents the oldest entry to the CDB arbiter as a request/grant handshake. It back-pressures issue with `alu_ready` so that no completed result is lost while the ALU waits for a CDB slot. A squash input flushes all buffered results on branch recovery.

## Interface
- `DEPTH`, 4: number of FIFO entries; power of two, ≥ 2.
- `CNT_BITS`, `$clog2(DEPTH+1)`: width of the occupancy count.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result valid this cycle.
- `alu_dest_tag`  in  `PHYS_REG_BITS`  destination physical register from the ALU.
- `alu_result`  in  32  ALU result value.
- `alu_ready`  out  1  queue accepts a result this cycle; equals `count != DEPTH`.
- `squash`  in  1  synchronous flush of all entries.
- `cdb_req`  out  1  head entry available for broadcast.
- `cdb_grant`  in  1  arbiter grants the CDB to this queue this cycle.
- `cdb_tag`  out  `PHYS_REG_BITS`  tag being broadcast.
- `cdb_value`  out  32  value being broadcast.
- `count`  out  `CNT_BITS`  current occupancy.
- `overflow`  out  1  sticky: set when a result arrives while full.

## Operation
- Storage: `DEPTH` entries of {tag, value}, head/tail pointers of `$clog2(DEPTH)` bits wrapping modulo `DEPTH`, plus a registered `count`.
- Push: `alu_valid && alu_ready && !squash` writes the entry at the tail and increments the tail.
- Pop: `cdb_req && cdb_grant && !squash` increments the head.
- `cdb_req = (count != 0)`. `cdb_tag` and `cdb_value` come from the head entry and are 0 when empty.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. When full, `alu_ready = 0`, so a push is never accepted in the same cycle as a pop from full. There is no ready pass-through from `cdb_grant`.
- `alu_valid && !alu_ready`: the result is dropped, `overflow` is set to 1, and the set persists until reset.
- `squash`: at the next edge, head = tail = 0 and `count = 0`. Any push or grant in the same cycle is ignored. `overflow` is not cleared.
- `cdb_grant` while `cdb_req = 0` is a no-op.

## Timing
- Reset (`reset_n` low, asynchronous): head, tail, `count` and `overflow` go to 0. As a result `cdb_req = 0`, `cdb_tag = 0`, `cdb_value = 0` and `alu_ready = 1`. Entry storage is not reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Default latency: a result pushed at edge N is visible on `cdb_req`/`cdb_tag`/`cdb_value` during cycle N+1 if the queue was empty.
- Outputs `alu_ready`, `cdb_req` and `count` depend only on registered state. `cdb_tag`/`cdb_value` are a mux of registered state, except in bypass mode.
- Throughput: one push and one pop per cycle.

## Configuration
- `ALU_CDB_BYPASS_EN` defined: when `count == 0`, `alu_valid = 1` and `squash = 0`, the block asserts `cdb_req` combinationally and drives `cdb_tag`/`cdb_value` straight from the ALU inputs.
  - If `cdb_grant = 1` that cycle, the result is not enqueued and `count` stays 0.
  - Otherwise the result is enqueued normally.
  - Effective latency is 0 cycles.
- Not defined: there is no combinational path from `alu_*` to `cdb_*`, and the minimum latency is 1 cycle.

## Test plan
- Reset then single push: `alu_valid = 1`, tag 5, value 32'h1234 at cycle 1, grant held high. Expect `cdb_req = 1`, tag 5, value 32'h1234 in cycle 2 (cycle 1 with `ALU_CDB_BYPASS_EN`), then `count` returns to 0.
- Fill without grant: push tags 1–4 on consecutive cycles. Expect `count = 4` and `alu_ready = 0`. Then grant 4 cycles; expect tags pop in order 1,2,3,4 and `alu_ready` is 1 after the first pop.
- Overflow: with the queue full, drive `alu_valid = 1` with tag 9. Expect `count` stays 4, tag 9 never appears on the CDB, and `overflow = 1` until `reset_n` is pulsed.
- Steady stream: push every cycle with grant every cycle for 20 cycles, wrapping pointers several times. Expect `count` constant (1, or 0 with bypass) and the tags appear in order with no loss.
- Squash: with 3 entries queued, assert `squash` together with `alu_valid` and `cdb_grant`. Expect `count = 0` and `cdb_req = 0` next cycle, the pushed tag never broadcast, and `overflow` unchanged.
- Asynchronous reset mid-stream: drop `reset_n` between edges with 2 entries queued. Expect `cdb_req`, `count` and `cdb_value` to go to 0 immediately and `alu_ready = 1`.
